// File: rtl/dsp_out_accumulator.sv
// dsp_out_accumulator: multiply-accumulate back end for the registered DSP
// multiplier. Sums a run of unsigned products into a wider accumulator. A run
// ends on in_last or after len beats. The result is then held on an output
// handshake until it is consumed.
module dsp_out_accumulator #(
    parameter int DATA_WIDTH  = 4,
    parameter int ACC_WIDTH   = 12,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_last,
    input  logic [COUNT_WIDTH-1:0] len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_data,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ACC_WIDTH-1:0]   acc;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] len_q;
    logic                   overflow;

    logic                   accept;
    logic [COUNT_WIDTH-1:0] len_eff;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic [ACC_WIDTH:0]     sum;

    // Handshake flags are pure state decode, so there is no combinational
    // path from any input to in_ready or out_valid.
    assign in_ready     = (state != HOLD);
    assign out_valid    = (state == HOLD);
    assign accept       = in_valid && in_ready;
    assign out_data     = acc;
    assign out_count    = count;
    assign out_overflow = overflow;

    // Effective run length, next beat count and the widened sum.
    // The extra top bit of the sum is the carry-out used for overflow.
    always_comb begin
        len_eff   = (len == '0) ? COUNT_WIDTH'(1) : len;
        count_inc = count + COUNT_WIDTH'(1);
        sum       = {1'b0, acc} + (ACC_WIDTH + 1)'(in_data);
    end

    // State register; reset returns to IDLE and abandons any partial run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: a run finishes on in_last or when the beat count
    // reaches the latched length.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (in_last || (len_eff == COUNT_WIDTH'(1))) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept && (in_last || (count_inc == len_q))) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: the first beat reloads the accumulator, and later beats add to it.
    // Nothing changes while holding, so the result stays stable until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            count    <= '0;
            len_q    <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                acc      <= ACC_WIDTH'(in_data);
                count    <= COUNT_WIDTH'(1);
                len_q    <= len_eff;
                overflow <= 1'b0;
            end else begin
                acc      <= sum[ACC_WIDTH-1:0];
                count    <= count_inc;
                overflow <= overflow | sum[ACC_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_dsp_out_accumulator.sv
// Testbench for dsp_out_accumulator. Directed scenarios are followed by
// randomized traffic. The DUT is compared against a run-level reference model
// that keeps a plain integer sum of the beats in the current run.
module tb_dsp_out_accumulator;

    localparam int DATA_W  = 4;
    localparam int ACC_W   = 5;
    localparam int COUNT_W = 4;
    localparam int ACC_MOD = 1 << ACC_W;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic               in_last;
    logic [COUNT_W-1:0] len;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_data;
    logic [COUNT_W-1:0] out_count;
    logic               out_overflow;

    int num_compared;
    int num_mismatched;

    // Reference model state. A run is described by its beats, its true sum
    // and its effective length. When the run finishes, the model holds the
    // expected result.
    bit model_in_run;
    bit model_holding;
    int model_sum;
    int model_beats;
    int model_len;
    int exp_data;
    int exp_count;
    int exp_ovf;

    dsp_out_accumulator #(
        .DATA_WIDTH (DATA_W),
        .ACC_WIDTH  (ACC_W),
        .COUNT_WIDTH(COUNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .len         (len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_count   (out_count),
        .out_overflow(out_overflow)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        num_compared++;
        if (observed != expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelClear();
        model_in_run  = 0;
        model_holding = 0;
        model_sum     = 0;
        model_beats   = 0;
        model_len     = 0;
    endtask

    // Hold rst_n low for the given number of cycles.
    // Then check the reset values a little after the rising edge.
    task automatic doReset(input int cycles);
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        len       = '0;
        out_ready = 1'b0;
        repeat (cycles) @(posedge clk);
        modelClear();
        #2;
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_out_count", int'(out_count), 0);
        checkOutput("rst_out_ovf", int'(out_overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle of stimulus. Drive inputs on the falling edge, compare
    // the handshake flags and any held result, advance the model, then let
    // the rising edge act.
    task automatic applyStimulus(input bit v, input logic [DATA_W-1:0] d, input bit l,
                                 input logic [COUNT_W-1:0] ln, input bit ordy);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        len       = ln;
        out_ready = ordy;
        #1;
        checkOutput("in_ready", int'(in_ready), model_holding ? 0 : 1);
        checkOutput("out_valid", int'(out_valid), model_holding ? 1 : 0);
        if (model_holding) begin
            checkOutput("out_data", int'(out_data), exp_data);
            checkOutput("out_count", int'(out_count), exp_count);
            checkOutput("out_overflow", int'(out_overflow), exp_ovf);
        end
        if (model_holding) begin
            if (ordy) model_holding = 0;
        end else if (v) begin
            if (!model_in_run) begin
                model_in_run = 1;
                model_sum    = 0;
                model_beats  = 0;
                model_len    = (int'(ln) == 0) ? 1 : int'(ln);
            end
            model_sum   += int'(d);
            model_beats += 1;
            if (l || model_beats == model_len) begin
                exp_data      = model_sum % ACC_MOD;
                exp_count     = model_beats;
                exp_ovf       = (model_sum > ACC_MOD - 1) ? 1 : 0;
                model_holding = 1;
                model_in_run  = 0;
            end
        end
        @(posedge clk);
    endtask

    // Compare a held result against fixed expected values, shortly after the edge.
    task automatic checkResult(input string tag, input int d, input int c, input int o);
        #2;
        checkOutput({tag, "_valid"}, int'(out_valid), 1);
        checkOutput({tag, "_ready"}, int'(in_ready), 0);
        checkOutput({tag, "_data"}, int'(out_data), d);
        checkOutput({tag, "_count"}, int'(out_count), c);
        checkOutput({tag, "_ovf"}, int'(out_overflow), o);
    endtask

    initial begin
        num_compared   = 0;
        num_mismatched = 0;
        rst_n          = 1'b0;
        modelClear();
        exp_data  = 0;
        exp_count = 0;
        exp_ovf   = 0;

        doReset(2);

        // len=3, beats 5,7,9
        applyStimulus(1, 4'd5, 0, 4'd3, 0);
        applyStimulus(1, 4'd7, 0, 4'd3, 0);
        applyStimulus(1, 4'd9, 0, 4'd3, 0);
        checkResult("t1", 21, 3, 0);
        applyStimulus(0, 4'd0, 0, 4'd0, 1);

        // len=0 is treated as 1
        applyStimulus(1, 4'd15, 0, 4'd0, 0);
        checkResult("t2", 15, 1, 0);
        applyStimulus(1, 4'd3, 0, 4'd2, 0);
        applyStimulus(0, 4'd0, 0, 4'd0, 1);

        // early in_last; a len change mid-run is ignored
        applyStimulus(1, 4'd2, 0, 4'd8, 0);
        applyStimulus(1, 4'd3, 0, 4'd1, 0);
        applyStimulus(1, 4'd4, 1, 4'd1, 0);
        checkResult("t3", 9, 3, 0);
        applyStimulus(0, 4'd0, 0, 4'd0, 1);

        // wrap with overflow, then overflow clears on the next run
        applyStimulus(1, 4'd15, 0, 4'd3, 0);
        applyStimulus(1, 4'd15, 0, 4'd3, 0);
        applyStimulus(1, 4'd15, 0, 4'd3, 0);
        checkResult("t4a", 13, 3, 1);
        applyStimulus(0, 4'd0, 0, 4'd0, 1);
        applyStimulus(1, 4'd1, 0, 4'd1, 0);
        checkResult("t4b", 1, 1, 0);

        // back-pressure in HOLD with a pending beat of 4
        for (int i = 0; i < 5; i++) applyStimulus(1, 4'd4, 0, 4'd1, 0);
        checkResult("t5a", 1, 1, 0);
        applyStimulus(1, 4'd4, 0, 4'd1, 1);
        applyStimulus(1, 4'd4, 0, 4'd1, 0);
        checkResult("t5b", 4, 1, 0);
        applyStimulus(0, 4'd0, 0, 4'd0, 1);

        // reset in the middle of a run
        applyStimulus(1, 4'd6, 0, 4'd4, 0);
        applyStimulus(1, 4'd6, 0, 4'd4, 0);
        doReset(1);
        applyStimulus(1, 4'd1, 0, 4'd2, 0);
        applyStimulus(1, 4'd1, 0, 4'd2, 0);
        checkResult("t6", 2, 2, 0);
        applyStimulus(0, 4'd0, 0, 4'd0, 1);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                doReset(1);
            end else begin
                applyStimulus($urandom_range(0, 3) != 0,
                              4'($urandom_range(0, 15)),
                              $urandom_range(0, 7) == 0,
                              4'($urandom_range(0, 15)),
                              $urandom_range(0, 2) != 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule

// File: doc/dsp_out_accumulator.md
Name: dsp_out_accumulator

Overview:
- Downstream stage of the registered DSP multiplier.
- Consumes its DATA_WIDTH-bit product stream with a valid/ready handshake and sums a run of products into a wider unsigned accumulator.
- Presents the finished sum, beat count and overflow flag on an output handshake, as a multiply-accumulate back end in the DSP test designs.
- Single clock domain, driven by the same clock as the DSP output register.

Parameters:
- DATA_WIDTH, 4, width of each incoming product (matches the DSP output width).
- ACC_WIDTH, 12, accumulator and result width; must be greater than DATA_WIDTH.
- COUNT_WIDTH, 4, width of the run-length and beat-count fields.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  DATA_WIDTH  unsigned product from the DSP.
- in_last  input  1  beat ends the run early; only meaningful when the beat is accepted.
- len  input  COUNT_WIDTH  run length; sampled only on the first beat of a run; 0 is treated as 1.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  ACC_WIDTH  accumulated sum.
- out_count  output  COUNT_WIDTH  number of beats summed.
- out_overflow  output  1  sum exceeded 2^ACC_WIDTH-1 at some point in the run.

Behaviour:
- Clock and reset decided: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge): state=IDLE, acc=0, count=0, len_q=0, overflow=0, out_valid=0.
  - in_ready=1 from the first cycle after reset is released.
  - Reset wins over every other event, including mid-run and during HOLD; a partial sum is discarded.
- Accept: a beat is taken when in_valid&&in_ready at a rising edge. Result: out_valid&&out_ready.
- States and transitions:
  - IDLE: in_ready=1, out_valid=0. On accept: acc<=zero-extended in_data; count<=1; overflow<=0; len_q<=(len==0?1:len).
    - Go to HOLD if in_last=1 or the effective len is 1; otherwise go to ACC.
  - ACC: in_ready=1, out_valid=0. On accept: acc<=acc+in_data (mod 2^ACC_WIDTH); count<=count+1; overflow<=overflow|carry-out.
    - Go to HOLD if in_last=1 or count+1==len_q. len is ignored in this state.
  - HOLD: in_ready=0, out_valid=1. out_data=acc, out_count=count, out_overflow=overflow, all stable until the result handshake.
    - On result handshake: go to IDLE next cycle. acc is not cleared; it is reloaded on the next first beat.
- Latency: out_valid rises the cycle after the last beat is accepted.
- Throughput: one bubble cycle minimum between runs (the HOLD cycle, plus the IDLE cycle before the next accept is possible only through HOLD→IDLE).
- out_valid must never drop without a handshake; out_data must not change while out_valid=1 and out_ready=0.
- Arithmetic is unsigned; wrap is modulo 2^ACC_WIDTH.
  - overflow is sticky within a run and cleared at the first beat of the next run.
- in_valid=0 cycles inside a run do not advance count and do not change acc.
- in_data, in_last and len are don't-care when in_valid=0.
- count saturation cannot occur because len_q≤2^COUNT_WIDTH-1. in_last on the len_q-th beat behaves identically to no in_last.
- Outputs are registered state plus decode of state only; there is no combinational path from in_* to out_*, or from out_ready to in_ready.

Test Plan:
- Reset, then len=3 with beats 5,7,9 back-to-back → out_valid 1 cycle after the 3rd accept; out_data=21, out_count=3, out_overflow=0.
- len=0, single beat 15 → treated as len 1; out_data=15, out_count=1; in_ready=0 during HOLD.
- len=8, beats 2,3,4 with in_last on the 3rd → out_data=9, out_count=3; a len change mid-run has no effect.
- ACC_WIDTH=5 override, len=3, beats 15,15,15 → out_data=45 mod 32=13, out_overflow=1; next run of len=1 with beat 1 → out_overflow=0.
- Hold out_ready=0 for 5 cycles in HOLD while driving in_valid=1 with value 4 → out_data stable, no beat accepted; release → IDLE, then 4 is accepted as the first beat of a new run.
- rst_n=0 for 1 cycle after 2 of 4 beats → next cycle IDLE, out_valid=0; new run len=2 with beats 1,1 → out_data=2, out_count=2.
